// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter: round-robin A/B arbiter for a single-port data memory with     |
// | locked B bursts and out-of-range write blocking. Optional: DMEM_ARB_STATS_EN |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       a_gnt_cnt,
  output logic [15:0]       b_gnt_cnt
`endif
);

  localparam int                 C_CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W:0]    C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_MAX   = C_CNT_W'(MAX_BURST);

  typedef enum logic [0:0] {
    S_ARB   = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_ptr;       // 0: A has priority, 1: B has priority
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_a_rvalid, r_b_rvalid, r_err;
  logic [DATA_W-1:0]  r_a_rdata, r_b_rdata;

  logic               w_a_gnt, w_b_gnt, w_any_gnt;
  logic               w_a_inr, w_b_inr, w_sel_inr, w_sel_we;
  logic [C_CNT_W-1:0] w_run_next;

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (r_state == S_BURST && b_req) begin
      w_b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      w_b_gnt = r_ptr;
      w_a_gnt = ~r_ptr;
    end else begin
      w_a_gnt = a_req;
      w_b_gnt = b_req;
    end
  end

  assign w_any_gnt  = w_a_gnt | w_b_gnt;
  assign w_a_inr    = ({1'b0, a_addr} < C_DEPTH);
  assign w_b_inr    = ({1'b0, b_addr} < C_DEPTH);
  assign w_sel_inr  = w_b_gnt ? w_b_inr : w_a_inr;
  assign w_sel_we   = w_b_gnt ? b_we : a_we;
  assign w_run_next = ((r_state == S_BURST) ? r_cnt : '0) + C_CNT_W'(1);

  assign mem_addr  = w_b_gnt ? b_addr : a_addr;
  assign mem_wdata = w_b_gnt ? b_wdata : a_wdata;
  // Grants stay visible during reset, but nothing may reach the memory array.
  assign mem_we    = w_any_gnt & w_sel_we & w_sel_inr & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ARB;
      r_ptr      <= 1'b0;
      r_cnt      <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_a_gnt) r_ptr <= 1'b1;
      else if (w_b_gnt) r_ptr <= 1'b0;

      // Hitting the beat limit drops back to arbitration; B lost priority on its grant.
      if (w_b_gnt && b_lock && (w_run_next < C_MAX)) begin
        r_state <= S_BURST;
        r_cnt   <= w_run_next;
      end else begin
        r_state <= S_ARB;
        r_cnt   <= '0;
      end

      r_a_rvalid <= w_a_gnt & ~a_we;
      if (w_a_gnt && !a_we) r_a_rdata <= w_a_inr ? mem_rdata : '0;
      r_b_rvalid <= w_b_gnt & ~b_we;
      if (w_b_gnt && !b_we) r_b_rdata <= w_b_inr ? mem_rdata : '0;
      r_err <= w_any_gnt & ~w_sel_inr;
    end
  end

  assign a_gnt    = w_a_gnt;
  assign b_gnt    = w_b_gnt;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign err      = r_err;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_a_cnt, r_b_cnt;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_a_gnt && r_a_cnt != 16'hFFFF) r_a_cnt <= r_a_cnt + 16'd1;
      if (w_b_gnt && r_b_cnt != 16'hFFFF) r_b_cnt <= r_b_cnt + 16'd1;
    end
  end

  assign a_gnt_cnt = r_a_cnt;
  assign b_gnt_cnt = r_b_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory between the core load/store path (port A) and a DMA/program-loader master (port B).
- Grants at most one access per clock and drives the memory's write-enable, address and write-data inputs.
- Captures the memory's asynchronous read data into a registered response.
- Enforces round-robin fairness, supports locked bursts from port B, and blocks writes to out-of-range addresses.

Parameters:
- DATA_W, 32, data width of memory and both ports
- ADDR_W, 32, address width (word index, as driven to memory)
- DEPTH, 256, number of valid memory words; addresses >= DEPTH are out of range
- MAX_BURST, 8, maximum consecutive grants to port B while lock is held (>=1)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- a_req  input  1  port A access request
- a_we  input  1  port A write (1) / read (0)
- a_addr  input  ADDR_W  port A word address
- a_wdata  input  DATA_W  port A write data
- a_gnt  output  1  port A granted this cycle (combinational)
- a_rvalid  output  1  port A read data valid (registered)
- a_rdata  output  DATA_W  port A read data (registered)
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: as port A, for port B
- b_lock  input  1  port B requests to keep the grant for the next cycle
- mem_we  output  1  to memory write enable (MemWriteM)
- mem_addr  output  ADDR_W  to memory address (ALUResultM)
- mem_wdata  output  DATA_W  to memory write data (WriteDataM)
- mem_rdata  input  DATA_W  from memory asynchronous read data (ReadData)
- err  output  1  one-cycle pulse: granted access was out of range

Behaviour:
- Reset: the following are all 0: a_rvalid, b_rvalid, a_rdata, b_rdata, err, burst counter, state. State = IDLE; priority pointer points to port A. Reset mid-burst abandons the burst. No response is issued for the reset cycle.
- States:
  - IDLE/ARB: normal arbitration.
  - B_BURST: port B holds the grant.
- Arbitration in ARB, single requester: that requester is granted.
- Arbitration in ARB, both requesting: the port indicated by the priority pointer wins. The pointer then moves to the other port.
- Pointer update: the pointer moves only on a grant, to the port that did not win.
- Enter B_BURST: when B is granted with b_lock=1. The burst counter loads 1.
- In B_BURST, B is granted if b_req=1, regardless of a_req.
- Each granted B beat with b_lock=1 increments the counter.
- Exit B_BURST to ARB when any of these holds:
  - b_lock=0 on a granted beat;
  - b_req=0;
  - the counter reaches MAX_BURST.
  On a MAX_BURST exit, the pointer points to A.
- Grant is combinational from the current inputs and state; a_gnt and b_gnt are never both 1.
- Memory drive:
  - mem_addr and mem_wdata are muxed from the granted port; they hold the port A values when idle.
  - mem_we = granted & we & (addr < DEPTH).
- Read latency is 1 cycle. For a granted read, mem_rdata is registered into x_rdata at the grant edge, and x_rvalid=1 for exactly the following cycle. Writes produce no rvalid.
- x_rdata holds its last value while rvalid=0.
- Out of range (addr >= DEPTH) on a granted access:
  - writes are suppressed;
  - reads return 0 with rvalid=1;
  - err pulses the cycle after the grant.
- Requesters must hold req/we/addr/wdata stable until they see gnt. An ungranted request has no side effects.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs a_gnt_cnt[15:0] and b_gnt_cnt[15:0].
  - Each counts granted accesses for its port and saturates at 16'hFFFF.
  - Both clear on rst.
  - Adds input stats_clr, a synchronous clear of both counters. If a grant occurs in the same cycle, the clear wins.
- Undefined: no counters, no extra ports, and no behavioural difference otherwise.

Test Plan:
- Reset: assert rst for 2 cycles with a_req=b_req=1 → a_gnt=1 combinationally, but no memory write; every output listed under Reset is 0 the cycle after rst falls.
- Single port: A writes 32'hDEADBEEF to address 5, then reads address 5 → mem_we=1 for the write; on the read, a_rvalid=1 one cycle after the grant with a_rdata=32'hDEADBEEF.
- Contention: a_req=b_req=1 continuously, b_lock=0 for 6 cycles → grants alternate A,B,A,B,A,B, with A first after reset.
- Burst: b_lock=1, b_req=1, a_req=1 for 12 cycles with MAX_BURST=8 → B is granted 8 consecutive cycles, then A is granted, then B resumes.
- Bounds: B writes 32'h1 to address 300, then reads address 300 → mem_we=0; err pulses once per access; b_rdata=0 with b_rvalid=1.
- Stats (DMEM_ARB_STATS_EN defined): 5 A grants and 3 B grants → a_gnt_cnt=5, b_gnt_cnt=3. Then stats_clr=1 together with an A grant → both counters read 0 the next cycle.
